// File: rtl/inst_seq_player_if.sv
// Program-load, playback-control and core-facing signals of inst_seq_player.
// SEQ_LOOP_EN adds the loop input.
interface inst_seq_player_if #(
  parameter int unsigned INST_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              ld_we;
  logic [AW-1:0]     ld_addr;
  logic [INST_W-1:0] ld_data;
  logic [AW:0]       ld_count;
  logic              start;
  logic              abort;
  logic              inst_ack;
  logic [INST_W-1:0] inst;
  logic              step;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic [AW-1:0]     pc;
`ifdef SEQ_LOOP_EN
  logic              loop;

  modport master (
    output ld_we, ld_addr, ld_data, ld_count, start, abort, inst_ack, loop,
    input  inst, step, busy, done, timeout_err, pc
  );

  modport slave (
    input  ld_we, ld_addr, ld_data, ld_count, start, abort, inst_ack, loop,
    output inst, step, busy, done, timeout_err, pc
  );
`else
  modport master (
    output ld_we, ld_addr, ld_data, ld_count, start, abort, inst_ack,
    input  inst, step, busy, done, timeout_err, pc
  );

  modport slave (
    input  ld_we, ld_addr, ld_data, ld_count, start, abort, inst_ack,
    output inst, step, busy, done, timeout_err, pc
  );
`endif

endinterface

// File: rtl/inst_seq_player.sv
// Instruction sequencer: plays a preloaded program into the calculator core's sw/btnS inputs.
// Optional feature: define SEQ_LOOP_EN to add the loop input (continuous replay).
module inst_seq_player #(
  parameter int unsigned INST_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned SETUP_CYC = 150000,
  parameter int unsigned PRESS_CYC = 300000,
  parameter int unsigned ACK_TMO   = 1000000
) (
  input logic               clk,
  input logic               rst_n,
  inst_seq_player_if.slave  bus
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MaxSp  = (SETUP_CYC > PRESS_CYC) ? SETUP_CYC : PRESS_CYC;
  localparam int unsigned MaxCyc = (MaxSp > ACK_TMO) ? MaxSp : ACK_TMO;
  localparam int unsigned TW     = $clog2(MaxCyc + 1);

  localparam logic [TW-1:0] TimerMax  = '1;
  localparam logic [TW-1:0] SetupLast = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PressLast = TW'(PRESS_CYC - 1);
  localparam logic [TW-1:0] TmoLast   = TW'(ACK_TMO - 1);
  localparam logic [AW:0]   DepthW    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntOne    = (AW + 1)'(1);
  localparam logic [AW-1:0] PcOne     = AW'(1);

  typedef enum logic [1:0] {StIdle, StSetup, StPress, StWaitAck} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ack_seen_q, ack_seen_d;

  logic [INST_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [AW:0]       cnt_clip;
  logic              last_inst;
  logic              loop_en;

`ifdef SEQ_LOOP_EN
  assign loop_en = bus.loop;
`else
  assign loop_en = 1'b0;
`endif

  // Program memory is only writable while idle so a running program cannot be corrupted.
  assign mem_we = bus.ld_we && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  assign cnt_clip  = (bus.ld_count > DepthW) ? DepthW : bus.ld_count;
  assign last_inst = ({1'b0, pc_q} == (cnt_q - CntOne));

  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == TimerMax) ? timer_q : timer_q + TW'(1);
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    step_d     = step_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    ack_seen_d = ack_seen_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d = cnt_clip;
          err_d = 1'b0;
          pc_d  = '0;
          if (cnt_clip == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = StSetup;
            busy_d     = 1'b1;
            timer_d    = '0;
            inst_d     = mem_q[0];
            ack_seen_d = 1'b0;
          end
        end
      end

      StSetup: begin
        if (timer_q == SetupLast) begin
          state_d    = StPress;
          step_d     = 1'b1;
          timer_d    = '0;
          ack_seen_d = 1'b0;
        end
      end

      StPress: begin
        if (bus.inst_ack) begin
          ack_seen_d = 1'b1;
        end
        // Timer keeps running into WAIT_ACK: the ack window is measured from the step edge.
        if (timer_q == PressLast) begin
          state_d = StWaitAck;
          step_d  = 1'b0;
        end
      end

      StWaitAck: begin
        if (ack_seen_q || bus.inst_ack) begin
          timer_d = '0;
          if (last_inst) begin
            done_d = 1'b1;
            if (loop_en) begin
              pc_d    = '0;
              inst_d  = mem_q[0];
              state_d = StSetup;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else begin
            pc_d    = pc_q + PcOne;
            inst_d  = mem_q[pc_q + PcOne];
            state_d = StSetup;
          end
        end else if (timer_q >= TmoLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (bus.abort) begin
      state_d    = StIdle;
      step_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      inst_d     = inst_q;
      ack_seen_d = ack_seen_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      cnt_q      <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  assign bus.inst        = inst_q;
  assign bus.step        = step_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = err_q;
  assign bus.pc          = pc_q;

  a_step_busy: assert property (@(posedge clk) disable iff (!rst_n) step_q |-> busy_q);
  a_step_state: assert property (@(posedge clk) disable iff (!rst_n)
                                 step_q |-> (state_q == StPress));

endmodule

// File: tb/tb_inst_seq_player.sv
// Directed bench for inst_seq_player (SETUP_CYC=4, PRESS_CYC=8, ACK_TMO=20, DEPTH=16).
// Build with SEQ_LOOP_EN defined to also exercise continuous replay.
module tb_inst_seq_player;

  localparam int unsigned INST_W = 8;
  localparam int unsigned DEPTH  = 16;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  // Per-run observations collected by run_play.
  logic [7:0] insts[$];
  int         press_len[$];
  int         n_press;
  int         n_done;
  int         rise_obs;
  int         err_obs;
  bit         hung;

  inst_seq_player_if #(.INST_W(INST_W), .DEPTH(DEPTH)) bus ();

  inst_seq_player #(
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .SETUP_CYC(4),
    .PRESS_CYC(8),
    .ACK_TMO  (20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [3:0] addr, input logic [7:0] data);
    bus.ld_we   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    tick();
    bus.ld_we = 1'b0;
  endtask

  // Pulses start and runs until busy falls, acking each PRESS on its 2nd high cycle
  // (except no_ack_idx) and aborting press abort_idx on its abort_cyc-th high cycle.
  task automatic run_play(input int no_ack_idx, input int abort_idx, input int abort_cyc,
                          input bit ld_busy, input int max_obs);
    int   cur;
    bit   exited;
    logic prev_step;
    logic prev_err;
    insts.delete();
    press_len.delete();
    n_press   = 0;
    n_done    = 0;
    rise_obs  = -1;
    err_obs   = -1;
    cur       = 0;
    exited    = 1'b0;
    prev_step = bus.step;
    prev_err  = bus.timeout_err;
    bus.start = 1'b1;
    for (int obs = 1; obs <= max_obs; obs++) begin
      tick();
      bus.start    = 1'b0;
      bus.inst_ack = 1'b0;
      bus.abort    = 1'b0;
      bus.ld_we    = 1'b0;
      if (bus.step && !prev_step) begin
        n_press++;
        insts.push_back(bus.inst);
        cur      = 0;
        rise_obs = obs;
      end
      if (bus.step) cur++;
      if (!bus.step && prev_step) press_len.push_back(cur);
      if (bus.done) n_done++;
      if (bus.timeout_err && !prev_err) err_obs = obs;
      prev_step = bus.step;
      prev_err  = bus.timeout_err;
      if (!bus.busy) begin
        exited = 1'b1;
        break;
      end
      if (bus.step && cur == 2 && (n_press - 1) != no_ack_idx) bus.inst_ack = 1'b1;
      if (bus.step && (n_press - 1) == abort_idx && cur == abort_cyc) bus.abort = 1'b1;
      if (ld_busy && obs == 1) begin
        bus.ld_we   = 1'b1;
        bus.ld_addr = 4'd0;
        bus.ld_data = 8'hFF;
      end
      if (obs == 5) bus.start = 1'b1;  // start while busy must be ignored
    end
    hung = !exited;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.step !== 1'b0) begin errors++;
      $display("FAIL reset_step: got %b want 0", bus.step); end
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.inst !== 8'h00) begin errors++;
      $display("FAIL reset_inst: got %h want 00", bus.inst); end
    checks++; if (bus.done !== 1'b0) begin errors++;
      $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++;
      $display("FAIL reset_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.pc !== 4'd0) begin errors++;
      $display("FAIL reset_pc: got %0d want 0", bus.pc); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_inst [3];
    exp_inst[0] = 8'h04;
    exp_inst[1] = 8'h00;
    exp_inst[2] = 8'h13;
    for (int i = 0; i < 3; i++) write_mem(4'(i), exp_inst[i]);
    bus.ld_count = 5'd3;
    run_play(-1, -1, 0, 1'b0, 200);
    checks++; if (hung !== 1'b0) begin errors++;
      $display("FAIL basic_finish: hung=%b want 0", hung); end
    checks++; if (n_press !== 3) begin errors++;
      $display("FAIL basic_presses: got %0d want 3", n_press); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (insts.size() <= i || insts[i] !== exp_inst[i]) begin errors++;
        $display("FAIL basic_inst%0d: got %h want %h", i,
                 (insts.size() > i) ? insts[i] : 8'hxx, exp_inst[i]); end
      checks++;
      if (press_len.size() <= i || press_len[i] !== 8) begin errors++;
        $display("FAIL basic_press_len%0d: got %0d want 8", i,
                 (press_len.size() > i) ? press_len[i] : -1); end
    end
    checks++; if (n_done !== 1 || bus.done !== 1'b1) begin errors++;
      $display("FAIL basic_done: count=%0d now=%b want 1/1", n_done, bus.done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++;
      $display("FAIL basic_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.pc !== 4'd2) begin errors++;
      $display("FAIL basic_pc: got %0d want 2", bus.pc); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++;
      $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    checks++; if (bus.inst !== 8'h13) begin errors++;
      $display("FAIL basic_inst_hold: got %h want 13", bus.inst); end
  endtask

  task automatic test_zero_count();
    bus.ld_count = 5'd0;
    run_play(-1, -1, 0, 1'b0, 10);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL zero_done: done=%b busy=%b want 1/0", bus.done, bus.busy); end
    repeat (3) begin
      tick();
      checks++; if (bus.step !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL zero_quiet: step=%b busy=%b done=%b want 0/0/0",
                 bus.step, bus.busy, bus.done); end
    end
  endtask

  task automatic test_timeout();
    bus.ld_count = 5'd3;
    run_play(1, -1, 0, 1'b0, 200);
    checks++; if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL tmo_err: err=%b busy=%b want 1/0", bus.timeout_err, bus.busy); end
    checks++; if ((err_obs - rise_obs) !== 20) begin errors++;
      $display("FAIL tmo_latency: got %0d want 20", err_obs - rise_obs); end
    checks++; if (bus.pc !== 4'd1 || n_press !== 2) begin errors++;
      $display("FAIL tmo_pc: pc=%0d presses=%0d want 1/2", bus.pc, n_press); end
    checks++; if (n_done !== 0) begin errors++;
      $display("FAIL tmo_no_done: got %0d want 0", n_done); end
    // abort and start together: start is dropped, so no done and err stays set
    bus.ld_count = 5'd0;
    bus.abort    = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.timeout_err !== 1'b1) begin errors++;
      $display("FAIL abort_beats_start: done=%b err=%b want 0/1", bus.done,
               bus.timeout_err); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0 || bus.done !== 1'b1) begin errors++;
      $display("FAIL tmo_clear: err=%b done=%b want 0/1", bus.timeout_err, bus.done); end
  endtask

  task automatic test_abort();
    bus.ld_count = 5'd3;
    run_play(-1, 1, 3, 1'b1, 200);
    checks++; if (bus.step !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL abort_stop: step=%b busy=%b want 0/0", bus.step, bus.busy); end
    checks++; if (n_press !== 2 || n_done !== 0) begin errors++;
      $display("FAIL abort_counts: presses=%0d done=%0d want 2/0", n_press, n_done); end
    checks++; if (bus.pc !== 4'd1) begin errors++;
      $display("FAIL abort_pc: got %0d want 1", bus.pc); end
    checks++; if (press_len.size() != 2 || press_len[1] !== 3) begin errors++;
      $display("FAIL abort_press_len: got %0d want 3",
               (press_len.size() > 1) ? press_len[1] : -1); end
    bus.ld_count = 5'd1;
    run_play(-1, -1, 0, 1'b0, 100);
    checks++; if (insts.size() != 1 || insts[0] !== 8'h04) begin errors++;
      $display("FAIL busy_write_blocked: got %h want 04",
               (insts.size() > 0) ? insts[0] : 8'hxx); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) write_mem(4'(i), 8'(i * 7 + 3));
    bus.ld_count = 5'd20;
    run_play(-1, -1, 0, 1'b0, 400);
    checks++; if (hung !== 1'b0 || n_press !== 16) begin errors++;
      $display("FAIL ovf_presses: got %0d hung=%b want 16/0", n_press, hung); end
    checks++; if (bus.pc !== 4'd15 || n_done !== 1) begin errors++;
      $display("FAIL ovf_end: pc=%0d done=%0d want 15/1", bus.pc, n_done); end
    checks++; if (insts.size() != 16 || insts[15] !== 8'h6C || insts[0] !== 8'h03) begin
      errors++;
      $display("FAIL ovf_insts: first=%h last=%h want 03/6c",
               (insts.size() > 0) ? insts[0] : 8'hxx,
               (insts.size() > 15) ? insts[15] : 8'hxx); end
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    logic [7:0] exp_seq [5];
    write_mem(4'd0, 8'h5A);
    write_mem(4'd1, 8'hA5);
    exp_seq = '{8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
    bus.loop     = 1'b1;
    bus.ld_count = 5'd2;
    run_play(-1, 4, 3, 1'b0, 300);
    bus.loop = 1'b0;
    checks++; if (n_press !== 5 || hung !== 1'b0) begin errors++;
      $display("FAIL loop_presses: got %0d hung=%b want 5/0", n_press, hung); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (insts.size() <= i || insts[i] !== exp_seq[i]) begin errors++;
        $display("FAIL loop_inst%0d: got %h want %h", i,
                 (insts.size() > i) ? insts[i] : 8'hxx, exp_seq[i]); end
    end
    checks++; if (n_done !== 2 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL loop_done: done=%0d busy=%b want 2/0", n_done, bus.busy); end
  endtask
`endif

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    bus.ld_count = 5'd3;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.step) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (seen !== 1'b1) begin errors++;
      $display("FAIL arst_press_reached: got %b want 1", seen); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.step !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL arst_step: step=%b busy=%b want 0/0", bus.step, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (bus.done || bus.step || bus.busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL arst_quiet: activity=%b want 0", seen); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.ld_count = '0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.inst_ack = 1'b0;
`ifdef SEQ_LOOP_EN
    bus.loop     = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero_count();
    test_timeout();
    test_abort();
    test_overflow();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
